// File: rtl/fc_layer_sequencer.sv
// Job engine for one fully-connected layer pass: issues weight rows, lines up accumulator
// controls with the weight-memory read latency, then strobes activation and signals done.
module fc_layer_sequencer #(
   parameter int INPUT_NODES = 100,
   parameter int ADDR_WIDTH  = 8,
   parameter int MEM_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [ADDR_WIDTH-1:0] in_sel,
   output logic                  acc_en,
   output logic                  acc_clear,
   output logic                  act_en
);

   typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, ACT, DONE} state_t;

   typedef struct packed {
      logic                  en;
      logic [ADDR_WIDTH-1:0] addr;
      logic                  first;
   } beat_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(INPUT_NODES - 1);
   localparam logic [1:0]            LAST_DRAIN = 2'(MEM_LATENCY - 1);

   state_t                state, state_nxt;
   logic [1:0]            drain_cnt, drain_cnt_nxt;
   logic                  busy_nxt, done_nxt, mem_en_nxt, act_en_nxt;
   logic [ADDR_WIDTH-1:0] mem_addr_nxt;
   beat_t                 pipe [MEM_LATENCY];
   logic                  flush;

   // Next state and the registered outputs for the following cycle.
   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt     = state;
      drain_cnt_nxt = drain_cnt;
      busy_nxt      = 1'b0;
      done_nxt      = 1'b0;
      mem_en_nxt    = 1'b0;
      act_en_nxt    = 1'b0;
      mem_addr_nxt  = '0;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               state_nxt  = ISSUE;
               mem_en_nxt = 1'b1;
               busy_nxt   = 1'b1;
            end
         end
         ISSUE: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (mem_addr == LAST_ADDR) begin
               state_nxt     = DRAIN;
               drain_cnt_nxt = '0;
               busy_nxt      = 1'b1;
            end else begin
               mem_en_nxt   = 1'b1;
               mem_addr_nxt = mem_addr + 1'b1;
               busy_nxt     = 1'b1;
            end
         end
         DRAIN: begin
            if (abort) begin
               state_nxt = IDLE;
            end else begin
               busy_nxt = 1'b1;
               if (drain_cnt == LAST_DRAIN) begin
                  state_nxt  = ACT;
                  act_en_nxt = 1'b1;
               end else begin
                  drain_cnt_nxt = drain_cnt + 2'd1;
               end
            end
         end
         ACT: begin
            if (abort) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = DONE;
               done_nxt  = 1'b1;
               busy_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         drain_cnt <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         mem_en    <= 1'b0;
         mem_addr  <= '0;
         act_en    <= 1'b0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= drain_cnt_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         mem_en    <= mem_en_nxt;
         mem_addr  <= mem_addr_nxt;
         act_en    <= act_en_nxt;
      end
   end

   assign flush = abort && busy;

   // Latency pipe; mem_addr is 0 whenever mem_en is low, so in_sel idles at 0 for free.
   // NOTE: the pipe is only a few flops and must come up empty, so it is reset like any other state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < MEM_LATENCY; i++) pipe[i] <= '0;
      end else if (flush) begin
         for (int i = 0; i < MEM_LATENCY; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= '{en: mem_en, addr: mem_addr, first: mem_en && (mem_addr == '0)};
         for (int i = 1; i < MEM_LATENCY; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign acc_en    = pipe[MEM_LATENCY-1].en;
   assign in_sel    = pipe[MEM_LATENCY-1].addr;
   assign acc_clear = pipe[MEM_LATENCY-1].first;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Scoreboard bench: two sequencer instances (N=100/L=1 and N=4/L=3) against a cycle-offset model.
module tb_fc_layer_sequencer;

   localparam int AW  = 8;
   localparam int N_A = 100;
   localparam int L_A = 1;
   localparam int N_B = 4;
   localparam int L_B = 3;

   typedef struct packed {
      logic          busy;
      logic          done;
      logic          mem_en;
      logic [AW-1:0] mem_addr;
      logic [AW-1:0] in_sel;
      logic          acc_en;
      logic          acc_clear;
      logic          act_en;
   } outs_t;

   typedef struct packed {
      outs_t a;
      outs_t b;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;

   logic          busy_a, done_a, mem_en_a, acc_en_a, acc_clear_a, act_en_a;
   logic [AW-1:0] mem_addr_a, in_sel_a;
   logic          busy_b, done_b, mem_en_b, acc_en_b, acc_clear_b, act_en_b;
   logic [AW-1:0] mem_addr_b, in_sel_b;
   outs_t         o_a, o_b;

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];

   // Model: a pass is "active" with c = cycles since the start edge.
   bit act_a = 0, act_b = 0;
   int c_a = 0, c_b = 0;

   always #5 clk = ~clk;

   fc_layer_sequencer #(.INPUT_NODES(N_A), .ADDR_WIDTH(AW), .MEM_LATENCY(L_A)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
      .busy(busy_a), .done(done_a), .mem_en(mem_en_a), .mem_addr(mem_addr_a),
      .in_sel(in_sel_a), .acc_en(acc_en_a), .acc_clear(acc_clear_a), .act_en(act_en_a)
   );

   fc_layer_sequencer #(.INPUT_NODES(N_B), .ADDR_WIDTH(AW), .MEM_LATENCY(L_B)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
      .busy(busy_b), .done(done_b), .mem_en(mem_en_b), .mem_addr(mem_addr_b),
      .in_sel(in_sel_b), .acc_en(acc_en_b), .acc_clear(acc_clear_b), .act_en(act_en_b)
   );

   assign o_a = {busy_a, done_a, mem_en_a, mem_addr_a, in_sel_a, acc_en_a, acc_clear_a, act_en_a};
   assign o_b = {busy_b, done_b, mem_en_b, mem_addr_b, in_sel_b, acc_en_b, acc_clear_b, act_en_b};

   function automatic outs_t expect_outs(input bit active, input int c, input int n, input int l);
      outs_t o;
      o = '0;
      if (active) begin
         o.busy      = 1'b1;
         o.mem_en    = (c < n);
         o.mem_addr  = (c < n) ? AW'(c) : '0;
         o.acc_en    = (c >= l) && (c <= n - 1 + l);
         o.in_sel    = o.acc_en ? AW'(c - l) : '0;
         o.acc_clear = (c == l);
         o.act_en    = (c == n + l);
         o.done      = (c == n + l + 1);
      end
      return o;
   endfunction

   task automatic step(inout bit active, inout int c, input bit st, input bit ab,
                       input int n, input int l);
      if (active) begin
         if (ab || c == n + l + 1) active = 0;
         else c = c + 1;
      end else if (st && !ab) begin
         active = 1;
         c      = 0;
      end
   endtask

   function automatic string fmt(input outs_t o);
      return $sformatf("busy=%b done=%b mem_en=%b addr=%0d acc_en=%b in_sel=%0d clr=%b act=%b",
                       o.busy, o.done, o.mem_en, o.mem_addr, o.acc_en, o.in_sel,
                       o.acc_clear, o.act_en);
   endfunction

   task automatic check(input string name, input outs_t act, input outs_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got {%s} expected {%s}", name, $time, fmt(act), fmt(exp));
      end
   endtask

   // One clock of stimulus; the expectation for the cycle after the coming edge is queued.
   task automatic cycle(input bit r, input bit sa, input bit aa, input bit sb, input bit ab);
      exp_t e;
      @(negedge clk);
      reset   = r;
      start_a = sa;
      abort_a = aa;
      start_b = sb;
      abort_b = ab;
      if (r) begin
         act_a = 0;
         act_b = 0;
      end else begin
         step(act_a, c_a, sa, aa, N_A, L_A);
         step(act_b, c_b, sb, ab, N_B, L_B);
      end
      e.a = expect_outs(act_a, c_a, N_A, L_A);
      e.b = expect_outs(act_b, c_b, N_B, L_B);
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
   endtask

   // Monitor: compares whatever the DUTs present just after each edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pass_a", o_a, e.a);
            check("pass_b", o_b, e.b);
         end
      end
   end

   initial begin
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0);

      // Single pass on both instances.
      cycle(0, 1, 0, 1, 0);
      idle(110);

      // start held high: back-to-back passes with one idle cycle between.
      for (int i = 0; i < 300; i++) cycle(0, 1, 0, 1, 0);
      idle(110);

      // Abort mid-pass (a in ISSUE at c=50, b in DRAIN), then a fresh pass.
      cycle(0, 1, 0, 1, 0);
      for (int i = 0; i < 50; i++) cycle(0, 0, 0, 0, i == 4);
      cycle(0, 0, 1, 0, 0);
      idle(3);
      cycle(0, 1, 1, 0, 1);
      idle(2);
      cycle(0, 1, 0, 1, 0);
      idle(110);

      // Asynchronous reset in the middle of a cycle.
      cycle(0, 1, 0, 1, 0);
      idle(30);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("a_async_reset", o_a, '0);
      check("b_async_reset", o_b, '0);
      act_a = 0;
      act_b = 0;
      cycle(1, 0, 0, 0, 0);
      cycle(0, 1, 0, 1, 0);
      idle(110);

      // Start pulses during the pass and in the done cycle are ignored.
      cycle(0, 1, 0, 1, 0);
      idle(10);
      cycle(0, 1, 0, 1, 0);
      idle(91);
      cycle(0, 1, 0, 0, 0);
      idle(10);

      // Random start/abort traffic.
      for (int i = 0; i < 2000; i++)
         cycle(0, $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0);
      idle(110);

      @(posedge clk);
      #2;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
